// File: rtl/rv32i_trap_pkg.sv
// Shared encodings for the RV32I trap controller: FSM states, CSR bit
// positions, mtvec modes and the default timer-interrupt cause.
package rv32i_trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_TRAP     = 3'd2,
    ST_RET      = 3'd3,
    ST_REDIRECT = 3'd4
  } trap_state_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MTIP_BIT     = 7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam logic [31:0] IRQ_CAUSE_DEFAULT = 32'h8000_0007;

endpackage

// File: rtl/rv32i_trap_ctrl_if.sv
// Commit-stage, CSR-file and fetch-redirect signals seen by the trap controller.
// master = trap controller, slave = the surrounding core.
interface rv32i_trap_ctrl_if;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic [31:0] next_pc;
  logic        pipe_idle;
  logic [31:0] mstatus_in;
  logic [31:0] mie_in;
  logic [31:0] mip_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        exception_trigger;
  logic [31:0] exception_cause;
  logic [31:0] exception_pc;
  logic [31:0] exception_value;
  logic        mret_trigger;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  modport master (
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, next_pc, pipe_idle,
    input  mstatus_in, mie_in, mip_in, mtvec_in, mepc_in, redirect_ready,
    output exception_trigger, exception_cause, exception_pc, exception_value,
    output mret_trigger, stall, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    output exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, next_pc, pipe_idle,
    output mstatus_in, mie_in, mip_in, mtvec_in, mepc_in, redirect_ready,
    input  exception_trigger, exception_cause, exception_pc, exception_value,
    input  mret_trigger, stall, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/rv32i_trap_vec.sv
// Combinational trap-target calculator: mtvec base, optional vectored offset
// for interrupts, RESET_PC fallback when mtvec has not been programmed.
module rv32i_trap_vec
  import rv32i_trap_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  input  logic        is_irq,
  output logic [31:0] target
);

  logic [31:0] base;
  logic        unused_cause;

  assign unused_cause = ^cause[31:5];

  always_comb begin
    base = {mtvec[31:2], 2'b00};
    if (base == 32'h0) begin
      target = RESET_PC;
    end else if ((mtvec[1:0] == MTVEC_VECTORED) && is_irq) begin
      target = base + {25'b0, cause[4:0], 2'b00};
    end else begin
      // modes 10/11 are reserved and fall back to direct
      target = base;
    end
  end

endmodule

// File: rtl/rv32i_trap_ctrl.sv
// Trap entry/return sequencer: arbitrates exception > MRET > timer IRQ,
// strobes the CSR file for one cycle, then holds a single fetch redirect.
module rv32i_trap_ctrl
  import rv32i_trap_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] IRQ_CAUSE = IRQ_CAUSE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  rv32i_trap_ctrl_if.master bus
);

  trap_state_e state;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic [31:0] tval_q;
  logic [31:0] target_q;
  logic        is_irq_q;
  logic        irq_pend;
  logic [31:0] vec_target;
  logic        unused_bits;

  assign irq_pend = bus.mstatus_in[MSTATUS_MIE] & bus.mie_in[MTIP_BIT] & bus.mip_in[MTIP_BIT];

  assign unused_bits = ^{bus.mstatus_in[31:4], bus.mstatus_in[2:0],
                         bus.mie_in[31:8], bus.mie_in[6:0],
                         bus.mip_in[31:8], bus.mip_in[6:0], bus.mepc_in[0]};

  rv32i_trap_vec #(
    .RESET_PC(RESET_PC)
  ) u_vec (
    .mtvec (bus.mtvec_in),
    .cause (cause_q),
    .is_irq(is_irq_q),
    .target(vec_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cause_q  <= '0;
      pc_q     <= '0;
      tval_q   <= '0;
      target_q <= '0;
      is_irq_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.exc_valid) begin
            cause_q  <= bus.exc_cause;
            pc_q     <= bus.exc_pc;
            tval_q   <= bus.exc_tval;
            is_irq_q <= 1'b0;
            state    <= ST_TRAP;
          end else if (bus.mret_valid) begin
            state <= ST_RET;
          end else if (irq_pend) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.exc_valid) begin
            cause_q  <= bus.exc_cause;
            pc_q     <= bus.exc_pc;
            tval_q   <= bus.exc_tval;
            is_irq_q <= 1'b0;
            state    <= ST_TRAP;
          end else if (!irq_pend) begin
            state <= ST_IDLE;
          end else if (bus.pipe_idle) begin
            cause_q  <= IRQ_CAUSE;
            pc_q     <= bus.next_pc;
            tval_q   <= '0;
            is_irq_q <= 1'b1;
            state    <= ST_TRAP;
          end
        end
        ST_TRAP: begin
          target_q <= vec_target;
          state    <= ST_REDIRECT;
        end
        ST_RET: begin
          target_q <= {bus.mepc_in[31:1], 1'b0};
          state    <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  // The IDLE cycle that spots a pending IRQ already freezes fetch/decode.
  assign bus.stall = (state != ST_IDLE) |
                     (irq_pend & ~bus.exc_valid & ~bus.mret_valid);

  always_comb begin
    bus.flush = 1'b0;
    if (state == ST_IDLE) begin
      bus.flush = bus.exc_valid | bus.mret_valid;
    end else if (state == ST_DRAIN) begin
      bus.flush = bus.exc_valid | (irq_pend & bus.pipe_idle);
    end
  end

  assign bus.exception_trigger = (state == ST_TRAP);
  assign bus.exception_cause   = cause_q;
  assign bus.exception_pc      = pc_q;
  assign bus.exception_value   = tval_q;
  assign bus.mret_trigger      = (state == ST_RET);
  assign bus.redirect_valid    = (state == ST_REDIRECT);
  assign bus.redirect_pc       = target_q;

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Directed bench for rv32i_trap_ctrl: per-cycle vector table for the main
// flows plus hand-written sequences for pre-emption, withdrawal and reset.
module tb_rv32i_trap_ctrl;

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic        busy;
    logic        etrig;
    logic        mtrig;
    logic        rvld;
    logic [31:0] rpc;
    logic [31:0] ecause;
    logic [31:0] epc;
    logic [31:0] eval;
  } out_t;

  typedef struct {
    string       name;
    logic        exc;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic        mret;
    logic [31:0] npc;
    logic        pidle;
    logic        irq;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        rdy;
    out_t        exp;
  } vec_t;

  localparam int NVEC = 20;
  localparam logic [31:0] IRQC = 32'h8000_0007;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  vec_t tbl[NVEC];

  rv32i_trap_ctrl_if bus ();

  rv32i_trap_ctrl #(
    .RESET_PC (32'h0000_0000),
    .IRQ_CAUSE(32'h8000_0007)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic out_t mko(logic fl, logic st, logic bz, logic et, logic mt, logic rv,
                               logic [31:0] rpc, logic [31:0] ec, logic [31:0] ep, logic [31:0] ev);
    out_t o;
    o.flush = fl; o.stall = st; o.busy = bz; o.etrig = et; o.mtrig = mt; o.rvld = rv;
    o.rpc = rpc; o.ecause = ec; o.epc = ep; o.eval = ev;
    return o;
  endfunction

  function automatic vec_t mkv(string nm, logic e, logic [31:0] c, logic [31:0] p, logic [31:0] t,
                               logic m, logic [31:0] np, logic pi, logic irq, logic [31:0] tv,
                               logic [31:0] ep, logic rd, out_t x);
    vec_t v;
    v.name = nm; v.exc = e; v.cause = c; v.pc = p; v.tval = t; v.mret = m; v.npc = np;
    v.pidle = pi; v.irq = irq; v.mtvec = tv; v.mepc = ep; v.rdy = rd; v.exp = x;
    return v;
  endfunction

  function automatic out_t get_out();
    return mko(bus.flush, bus.stall, bus.busy, bus.exception_trigger, bus.mret_trigger,
               bus.redirect_valid, bus.redirect_pc, bus.exception_cause,
               bus.exception_pc, bus.exception_value);
  endfunction

  task automatic chko(input string nm, input out_t got, input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.exc_valid      = 1'b0;
    bus.exc_cause      = '0;
    bus.exc_pc         = '0;
    bus.exc_tval       = '0;
    bus.mret_valid     = 1'b0;
    bus.next_pc        = '0;
    bus.pipe_idle      = 1'b0;
    bus.mstatus_in     = 32'h8;
    bus.mie_in         = '0;
    bus.mip_in         = 32'h80;
    bus.mtvec_in       = 32'h100;
    bus.mepc_in        = 32'h123;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.exc_valid      = v.exc;
    bus.exc_cause      = v.cause;
    bus.exc_pc         = v.pc;
    bus.exc_tval       = v.tval;
    bus.mret_valid     = v.mret;
    bus.next_pc        = v.npc;
    bus.pipe_idle      = v.pidle;
    bus.mstatus_in     = 32'h8;
    bus.mie_in         = v.irq ? 32'h80 : 32'h0;
    bus.mip_in         = 32'h80;
    bus.mtvec_in       = v.mtvec;
    bus.mepc_in        = v.mepc;
    bus.redirect_ready = v.rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy == 1'b0) break;
      cyc();
    end
    chk(nm, {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    logic seen;
    n_chk  = 0;
    n_fail = 0;

    tbl[0]  = mkv("idle0",      0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h123, 0, mko(0,0,0,0,0,0, 0, 0, 0, 0));
    tbl[1]  = mkv("exc_n",      1, 2, 32'h40, 32'hDEAD, 0, 0, 0, 0, 32'h100, 32'h123, 0, mko(1,0,0,0,0,0, 0, 0, 0, 0));
    tbl[2]  = mkv("exc_trap",   0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h123, 0, mko(0,1,1,1,0,0, 0, 2, 32'h40, 32'hDEAD));
    tbl[3]  = mkv("exc_redir",  0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h123, 1, mko(0,1,1,0,0,1, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[4]  = mkv("exc_done",   0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h123, 0, mko(0,0,0,0,0,0, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[5]  = mkv("irq_detect", 0, 0, 0, 0, 0, 32'h88, 0, 1, 32'h201, 32'h123, 0, mko(0,1,0,0,0,0, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[6]  = mkv("irq_drain1", 0, 0, 0, 0, 0, 32'h88, 0, 1, 32'h201, 32'h123, 0, mko(0,1,1,0,0,0, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[7]  = mkv("irq_drain2", 0, 0, 0, 0, 0, 32'h88, 0, 1, 32'h201, 32'h123, 0, mko(0,1,1,0,0,0, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[8]  = mkv("irq_drain3", 0, 0, 0, 0, 0, 32'h88, 1, 1, 32'h201, 32'h123, 0, mko(1,1,1,0,0,0, 32'h100, 2, 32'h40, 32'hDEAD));
    tbl[9]  = mkv("irq_trap",   0, 0, 0, 0, 0, 32'h88, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,1,0,0, 32'h100, IRQC, 32'h88, 0));
    tbl[10] = mkv("irq_redir",  0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 1, mko(0,1,1,0,0,1, 32'h21C, IRQC, 32'h88, 0));
    tbl[11] = mkv("irq_done",   0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,0,0,0,0,0, 32'h21C, IRQC, 32'h88, 0));
    tbl[12] = mkv("mret_n",     0, 0, 0, 0, 1, 0, 0, 0, 32'h201, 32'h123, 0, mko(1,0,0,0,0,0, 32'h21C, IRQC, 32'h88, 0));
    tbl[13] = mkv("mret_ret",   0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,0,1,0, 32'h21C, IRQC, 32'h88, 0));
    tbl[14] = mkv("mret_hold1", 0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,0,0,1, 32'h122, IRQC, 32'h88, 0));
    tbl[15] = mkv("mret_hold2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,0,0,1, 32'h122, IRQC, 32'h88, 0));
    tbl[16] = mkv("mret_hold3", 0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,0,0,1, 32'h122, IRQC, 32'h88, 0));
    tbl[17] = mkv("mret_hold4", 0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,1,1,0,0,1, 32'h122, IRQC, 32'h88, 0));
    tbl[18] = mkv("mret_acc",   0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 1, mko(0,1,1,0,0,1, 32'h122, IRQC, 32'h88, 0));
    tbl[19] = mkv("mret_done",  0, 0, 0, 0, 0, 0, 0, 0, 32'h201, 32'h123, 0, mko(0,0,0,0,0,0, 32'h122, IRQC, 32'h88, 0));

    rst_n = 1'b0;
    drive_idle();
    #12;
    chko("reset", get_out(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i]);
      #1;
      chko(tbl[i].name, get_out(), tbl[i].exp);
      cyc();
    end

    // exception arriving while an IRQ is draining takes over
    drive_idle();
    bus.mie_in = 32'h80;
    #1;
    chk("pre_detect_stall", {31'b0, bus.stall}, 32'h1);
    cyc();
    bus.exc_valid = 1'b1;
    bus.exc_cause = 32'd5;
    bus.exc_pc    = 32'h60;
    bus.exc_tval  = 32'h7;
    #1;
    chk("pre_flush", {31'b0, bus.flush}, 32'h1);
    cyc();
    bus.exc_valid = 1'b0;
    bus.mie_in    = 32'h0;
    #1;
    chk("pre_etrig", {31'b0, bus.exception_trigger}, 32'h1);
    chk("pre_cause", bus.exception_cause, 32'd5);
    chk("pre_pc", bus.exception_pc, 32'h60);
    bus.redirect_ready = 1'b1;
    cyc();
    chk("pre_redir_pc", bus.redirect_pc, 32'h100);
    wait_idle("pre_idle");

    // IRQ withdrawn before the pipeline drains
    drive_idle();
    bus.mie_in = 32'h80;
    cyc();
    chk("wd_drain_busy", {31'b0, bus.busy}, 32'h1);
    bus.mie_in = 32'h0;
    #1;
    chk("wd_no_flush", {31'b0, bus.flush}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      seen = seen | bus.exception_trigger;
    end
    chk("wd_stall", {31'b0, bus.stall}, 32'h0);
    chk("wd_busy", {31'b0, bus.busy}, 32'h0);
    chk("wd_no_etrig", {31'b0, seen}, 32'h0);

    // simultaneous exception and MRET: exception wins
    drive_idle();
    bus.exc_valid  = 1'b1;
    bus.exc_cause  = 32'd3;
    bus.exc_pc     = 32'h70;
    bus.mret_valid = 1'b1;
    #1;
    chk("sim_flush", {31'b0, bus.flush}, 32'h1);
    cyc();
    bus.exc_valid  = 1'b0;
    bus.mret_valid = 1'b0;
    #1;
    chk("sim_etrig", {31'b0, bus.exception_trigger}, 32'h1);
    chk("sim_mtrig", {31'b0, bus.mret_trigger}, 32'h0);
    chk("sim_cause", bus.exception_cause, 32'd3);
    cyc();
    chk("sim_mtrig2", {31'b0, bus.mret_trigger}, 32'h0);
    chk("sim_rvld", {31'b0, bus.redirect_valid}, 32'h1);
    chk("sim_rpc", bus.redirect_pc, 32'h100);

    // asynchronous reset while the redirect is still pending
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chko("rst_redirect", get_out(), '0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chko("rst_after", get_out(), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_trap_ctrl.md
Name: rv32i_trap_ctrl

Overview:
- Sequences trap entry and trap return for the RV32I core.
- Arbitrates between three sources: synchronous exceptions from the pipeline, MRET retirement, and the machine timer interrupt.
- Drives the CSR file's exception_trigger/cause/pc/value and mret_trigger inputs, then issues a single PC redirect (mtvec or mepc) to fetch.
- Sits between the pipeline's commit stage, the CSR file and the fetch unit.

Parameters:
- RESET_PC, 32'h0000_0000, redirect target used if mtvec is 0 at trap time; never otherwise substituted.
- IRQ_CAUSE, 32'h8000_0007, mcause value written for a machine timer interrupt.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- exc_valid  in  1  commit stage reports an exception this cycle
- exc_cause  in  32  exception cause code
- exc_pc  in  32  PC of the faulting instruction
- exc_tval  in  32  trap value for mtval
- mret_valid  in  1  MRET is at commit this cycle
- next_pc  in  32  PC of the oldest unretired instruction; mepc for interrupts
- pipe_idle  in  1  pipeline drained, no instruction in flight past decode
- mstatus_in  in  32  CSR mstatus
- mie_in  in  32  CSR mie
- mip_in  in  32  CSR mip
- mtvec_in  in  32  CSR mtvec
- mepc_in  in  32  CSR mepc
- exception_trigger  out  1  to CSR file
- exception_cause  out  32  to CSR file
- exception_pc  out  32  to CSR file
- exception_value  out  32  to CSR file
- mret_trigger  out  1  to CSR file
- stall  out  1  freeze fetch/decode while draining
- flush  out  1  kill all younger instructions, 1-cycle pulse
- redirect_valid  out  1  new PC available
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  FSM not IDLE

Behaviour:
- Reset: FSM = IDLE. All outputs are 0, including the latched cause/pc/tval registers.
- irq_pend = mstatus_in[3] & mie_in[7] & mip_in[7].
- FSM states: IDLE, DRAIN, TRAP, RET, REDIRECT.
- IDLE, priority exc_valid > mret_valid > irq_pend:
  - exc_valid: latch cause/pc/tval, is_irq=0, pulse flush, go TRAP.
  - mret_valid: pulse flush, go RET.
  - irq_pend: assert stall, go DRAIN.
- DRAIN:
  - stall stays high.
  - exc_valid: the exception pre-empts. Latch it and go TRAP.
  - irq_pend drops (e.g. software cleared mie) before pipe_idle: release stall, return to IDLE, no trap.
  - pipe_idle & irq_pend: latch cause=IRQ_CAUSE, pc=next_pc, tval=0, is_irq=1, pulse flush, go TRAP.
- TRAP:
  - exception_trigger=1 for exactly one cycle, with latched cause/pc/value.
  - Compute target from mtvec_in sampled this cycle:
    - mtvec[1:0]==01 and is_irq: {mtvec[31:2],2'b00} + 4*cause[4:0].
    - Otherwise: {mtvec[31:2],2'b00}.
    - Modes 10/11 are treated as direct.
    - If the resulting base is 0, target = RESET_PC.
  - Go REDIRECT.
- RET: mret_trigger=1 for exactly one cycle, target = {mepc_in[31:1],1'b0}, go REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=target; hold both stable until redirect_ready.
  - stall stays high.
  - On handshake, go IDLE next cycle.
  - exc_valid/mret_valid are ignored here (the pipeline is flushed).
- Latency:
  - Exception: exc_valid at cycle N gives exception_trigger at N+1 and redirect_valid from N+2.
  - MRET: mret_valid at cycle N gives mret_trigger at N+1 and redirect_valid from N+2.
- exception_trigger and mret_trigger are never high in the same cycle. flush is never high in TRAP, RET or REDIRECT.
- Interrupt re-entry is prevented because the CSR file clears mstatus.MIE on the TRAP edge. The FSM does not re-sample irq_pend until it is back in IDLE.
- Simultaneous exc_valid and mret_valid in IDLE: exception wins; MRET is dropped (it is younger or flushed).
- busy = (state != IDLE). stall = busy, except in the single IDLE cycle.
- Reset mid-operation returns to IDLE immediately. Pending redirect, latched cause and stall are all cleared.

Decomposition:
- Shared package rv32i_trap_pkg:
  - FSM state encodings (3-bit).
  - mstatus bit indices: MIE=3, MPIE=7.
  - mie/mip MTIP bit = 7.
  - mtvec mode constants.
  - IRQ_CAUSE default.
- One natural sub-module: rv32i_trap_vec, a combinational target-PC calculator (mtvec, cause, is_irq, RESET_PC) reused by future interrupt sources.
- FSM and latches stay in the top module.

Test Plan:
- Direct-mode exception: mtvec=0x0000_0100, exc_valid with cause=2, pc=0x40, tval=0xDEAD -> flush at N; exception_trigger at N+1 carrying 2/0x40/0xDEAD; redirect_pc=0x100 at N+2.
- Vectored timer IRQ: mtvec=0x0000_0201, mstatus=0x8, mie=0x80, mip=0x80, pipe_idle after 3 cycles, next_pc=0x88 -> stall for 3 cycles; exception_cause=0x8000_0007, pc=0x88; redirect_pc=0x21C.
- MRET: mepc=0x0000_0123, mret_valid -> mret_trigger 1 cycle; redirect_pc=0x122; redirect held for 4 cycles with redirect_ready=0, then accepted -> busy drops the next cycle.
- Exception pre-empts drain: IRQ pending in DRAIN, exc_valid cause=5 pc=0x60 -> exception_cause=5 (not 0x8000_0007).
- IRQ withdrawn mid-drain: mie cleared to 0 in DRAIN -> stall released, no exception_trigger, FSM back to IDLE.
- Simultaneous exc_valid and mret_valid in IDLE -> only exception_trigger pulses; mret_trigger stays 0. Separately, rst_n asserted while in REDIRECT -> all outputs 0 in the same cycle.
